// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and load clamping shared by the up/down modulo counter.
package counter_pkg;
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;
    function automatic int unsigned clamp_mod(input int unsigned val, input int unsigned mod);
        return (val >= mod) ? mod - 1 : val;
    endfunction
endpackage

// File: rtl/counter_next_state.sv
// counter_next_state: combinational step/wrap logic; UPDOWN_MOD_COUNTER_SATURATE_EN selects saturation.
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             en,
    output logic [WIDTH-1:0] nxt,
    output logic             at_limit,
    output logic             wrap_evt
);
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_lim;
    logic [WIDTH-1:0] w_lim_val;
    // One extra bit: up-limit is q+1==MOD, down-limit is the borrow out of q-1.
    assign w_inc = {1'b0, q} + 1'b1;
    assign w_dec = {1'b0, q} - 1'b1;
    assign w_lim = (up_dn == CNT_UP) ? (w_inc == (WIDTH+1)'(MOD)) : w_dec[WIDTH];
    assign at_limit = en & w_lim;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
    assign w_lim_val = q;
    assign wrap_evt  = 1'b0;
`else
    assign w_lim_val = (up_dn == CNT_DN) ? WIDTH'(MOD - 1) : '0;
    assign wrap_evt  = at_limit;
`endif
    assign nxt = !en ? q : w_lim ? w_lim_val : (up_dn == CNT_UP) ? w_inc[WIDTH-1:0] : w_dec[WIDTH-1:0];
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down modulo counter with load and carry chain.
// Build with UPDOWN_MOD_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic             w_at_limit;
    logic             w_wrap_evt;

    if (MOD < 2 || MOD > (2 ** WIDTH) || INIT >= MOD || INIT < 0) begin : g_bad_params
        $error("updown_mod_counter: need 2 <= MOD <= 2**WIDTH and 0 <= INIT < MOD");
    end

    counter_next_state #(.WIDTH(WIDTH), .MOD(MOD)) u_next (
        .q        (r_q),
        .up_dn    (up_dn),
        .en       (en),
        .nxt      (w_nxt),
        .at_limit (w_at_limit),
        .wrap_evt (w_wrap_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= WIDTH'(INIT);
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= WIDTH'(clamp_mod(32'(load_val), MOD));
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_nxt;
            r_wrap <= w_wrap_evt;
        end
    end

    assign q    = r_q;
    assign tc   = w_at_limit;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: vector table on a MOD=10 counter, plus cascade and binary-rollover sequences.
module tb_updown_mod_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [3:0] load_val = '0, q;
    logic       tc, wrap;

    logic       c_rst = 1'b0, c_en = 1'b0;
    logic [3:0] l_q, m_q;
    logic       l_tc, m_tc, l_wrap, m_wrap;

    logic       b_rst = 1'b0, b_en = 1'b0, b_up = 1'b1;
    logic [2:0] b_q;
    logic       b_tc, b_wrap;

    int checks = 0;
    int errors = 0;

    updown_mod_counter #(.WIDTH(4), .MOD(10), .INIT(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );
    updown_mod_counter #(.WIDTH(4), .MOD(10), .INIT(0)) u_lsd (
        .clk(clk), .rst(c_rst), .en(c_en), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .q(l_q), .tc(l_tc), .wrap(l_wrap)
    );
    updown_mod_counter #(.WIDTH(4), .MOD(10), .INIT(0)) u_msd (
        .clk(clk), .rst(c_rst), .en(l_tc), .up_dn(1'b1), .load(1'b0),
        .load_val(4'd0), .q(m_q), .tc(m_tc), .wrap(m_wrap)
    );
    updown_mod_counter #(.WIDTH(3), .MOD(8), .INIT(5)) u_bin (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(1'b0),
        .load_val(3'd0), .q(b_q), .tc(b_tc), .wrap(b_wrap)
    );

    typedef struct packed {
        logic       rst, en, up, ld;
        logic [3:0] lv, q;
        logic       tc, w;
    } vec_t;
    vec_t v[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // fields: rst en up ld lv | q tc wrap (q/wrap after the edge, tc with inputs held)
        v.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0});
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0});
`else
        for (int i = 1; i <= 8; i++) v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1});
        v.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0});
        for (int i = 6; i >= 1; i--) v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1});
`endif
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            rst = v[i].rst; en = v[i].en; up_dn = v[i].up; load = v[i].ld; load_val = v[i].lv;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i), 32'(q), 32'(v[i].q));
            check($sformatf("vec%0d_tc", i), 32'(tc), 32'(v[i].tc));
            check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(v[i].w));
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b0;
`ifndef UPDOWN_MOD_COUNTER_SATURATE_EN
        // Cascade: two decades form a 0..99 counter.
        c_rst = 1'b1;
        @(posedge clk);
        #1;
        check("chain_reset", {24'd0, m_q, l_q}, 32'd0);
        @(negedge clk);
        c_rst = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("chain_k%0d", k), 32'(m_q) * 10 + 32'(l_q), 32'(k % 100));
            if (k == 99) check("chain_msd_tc_at_99", 32'(m_tc), 32'd1);
            if (k == 100) check("chain_msd_wrap", 32'(m_wrap), 32'd1);
        end
        @(negedge clk);
        c_en = 1'b0;
        // Full binary modulus with a non-zero INIT.
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        check("bin_reset_init", 32'(b_q), 32'd5);
        @(negedge clk);
        b_rst = 1'b0; b_en = 1'b1; b_up = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bin_rollover_q", 32'(b_q), 32'd0);
        check("bin_rollover_wrap", 32'(b_wrap), 32'd1);
        @(negedge clk);
        b_up = 1'b0;
        @(posedge clk);
        #1;
        check("bin_down_q", 32'(b_q), 32'd7);
        check("bin_down_wrap", 32'(b_wrap), 32'd1);
        check("bin_down_tc", 32'(b_tc), 32'd0);
        b_up = 1'b1;
        #1;
        check("bin_tc_follows_dir", 32'(b_tc), 32'd1);
        @(negedge clk);
        b_en = 1'b0;
        #1;
        check("bin_tc_needs_en", 32'(b_tc), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
